// File: rtl/spi_arbiter_if.sv
// Client-side bus of spi_arbiter: burst requests, tx byte feed, rx byte and completion returns.
interface spi_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ*8-1:0]     tx_data;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       tx_pop;
    logic [NUM_REQ-1:0]       rx_valid;
    logic [7:0]               rx_data;
    logic [NUM_REQ-1:0]       done;

    // Handshake: req is a level held until done; req_len is sampled at grant. tx_data must
    // always hold the next byte and advances after each tx_pop pulse. rx_valid, done and
    // tx_pop are single-cycle pulses with no back-pressure, so clients must always accept them.
    modport master (
        output req, req_len, tx_data,
        input  grant, tx_pop, rx_valid, rx_data, done
    );
    modport slave (
        input  req, req_len, tx_data,
        output grant, tx_pop, rx_valid, rx_data, done
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one 8-bit SPI shift core among NUM_REQ burst requesters.
// Optional watchdog abort of hung transfers is compiled in with `define SPI_ARB_WDOG_EN.
module spi_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int LEN_W    = 4,
    parameter int WDOG_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    spi_arbiter_if.slave        bus,
    output logic                spi_start_o,
    output logic [7:0]          spi_data_in_o,
    input  logic                spi_busy_i,
    input  logic [7:0]          spi_data_out_i,
    output logic                err_o,
    output logic [1:0]          dbg_state_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYC < 2) begin : g_param_check
        $error("spi_arbiter: NUM_REQ must be 2..8 and WDOG_CYC at least 2");
    end

    state_t             state_q;
    logic [IDX_W-1:0]   winner_q;
    logic [IDX_W-1:0]   last_grant_q;
    logic [LEN_W-1:0]   byte_cnt_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] tx_pop_q;
    logic [NUM_REQ-1:0] rx_valid_q;
    logic [NUM_REQ-1:0] done_q;
    logic [7:0]         rx_data_q;
    logic [7:0]         spi_data_in_q;
    logic               spi_start_q;
    logic               err_q;
    logic [IDX_W:0]     pick_d;
    logic               wdog_hit;

    // First pending requester after the previous owner, wrapping; MSB flags a valid pick.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (r[idx]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    assign pick_d = rr_pick(bus.req, last_grant_q);

`ifdef SPI_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_q;
    logic            wdog_run;

    // Counts only while stalled in a wait state; any state change restarts it from zero.
    assign wdog_run = (state_q == S_WAIT_BUSY && !spi_busy_i) ||
                      (state_q == S_WAIT_DONE &&  spi_busy_i);
    assign wdog_hit = wdog_run && (wdog_q == WD_W'(WDOG_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (wdog_run && !wdog_hit) begin
            wdog_q <= wdog_q + 1'b1;
        end else begin
            wdog_q <= '0;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            winner_q      <= '0;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            byte_cnt_q    <= '0;
            grant_q       <= '0;
            tx_pop_q      <= '0;
            rx_valid_q    <= '0;
            done_q        <= '0;
            rx_data_q     <= '0;
            spi_data_in_q <= '0;
            spi_start_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            spi_start_q <= 1'b0;
            tx_pop_q    <= '0;
            rx_valid_q  <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_d[IDX_W]) begin
                        winner_q   <= pick_d[IDX_W-1:0];
                        grant_q    <= NUM_REQ'(1) << pick_d[IDX_W-1:0];
                        byte_cnt_q <= bus.req_len[int'(pick_d[IDX_W-1:0])*LEN_W +: LEN_W];
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    spi_start_q   <= 1'b1;
                    spi_data_in_q <= bus.tx_data[int'(winner_q)*8 +: 8];
                    tx_pop_q      <= grant_q;
                    state_q       <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (spi_busy_i) begin
                        state_q <= S_WAIT_DONE;
                    end else if (wdog_hit) begin
                        err_q        <= 1'b1;
                        done_q       <= grant_q;
                        grant_q      <= '0;
                        last_grant_q <= winner_q;
                        state_q      <= S_IDLE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!spi_busy_i) begin
                        rx_data_q  <= spi_data_out_i;
                        rx_valid_q <= grant_q;
                        if (byte_cnt_q != '0) begin
                            byte_cnt_q <= byte_cnt_q - 1'b1;
                            state_q    <= S_START;
                        end else begin
                            done_q       <= grant_q;
                            grant_q      <= '0;
                            last_grant_q <= winner_q;
                            state_q      <= S_IDLE;
                        end
                    end else if (wdog_hit) begin
                        // Hung byte produces no rx_valid; the rest of the burst is dropped.
                        err_q        <= 1'b1;
                        done_q       <= grant_q;
                        grant_q      <= '0;
                        last_grant_q <= winner_q;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.tx_pop    = tx_pop_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.done      = done_q;
    assign spi_start_o   = spi_start_q;
    assign spi_data_in_o = spi_data_in_q;
    assign err_o         = err_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: loopback SPI core model, transaction-level client and arbitration model.
module tb_spi_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int LEN_W    = 4;
    localparam int WDOG_CYC = 64;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_start;
    logic [7:0] spi_data_in;
    logic       spi_busy = 1'b0;
    logic [7:0] spi_data_out = '0;
    logic       err;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    spi_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus();

    spi_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .WDOG_CYC(WDOG_CYC)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .spi_start_o    (spi_start),
        .spi_data_in_o  (spi_data_in),
        .spi_busy_i     (spi_busy),
        .spi_data_out_i (spi_data_out),
        .err_o          (err),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];          // {requester, byte} in transfer order
    logic [7:0]  dir_q[$];          // scripted follow-on tx bytes
    int          grant_log[$];
    int          burst_left[NUM_REQ];
    int          cur_len[NUM_REQ];
    int          cur_idx[NUM_REQ];
    logic [7:0]  cur_byte[NUM_REQ];
    bit          drop_early[NUM_REQ];
    bit          in_burst[NUM_REQ];
    int          last_w, act_w, act_len, rx_left, n_start;
    bit          rand_mode, arb_next, core_stuck;
    logic [NUM_REQ-1:0] prev_grant;
    int          core_phase, core_cnt;
    logic [7:0]  core_latch;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        oh = '0;
        if (i >= 0) oh[i] = 1'b1;
    endfunction

    // Rotation rule: first pending requester strictly after the last owner.
    function automatic int rr_expect(input logic [NUM_REQ-1:0] p, input int last);
        for (int k = 1; k <= NUM_REQ; k++)
            if (p[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic bit quiet();
        quiet = (act_w < 0) && (core_phase == 0) && !core_stuck;
        for (int i = 0; i < NUM_REQ; i++) if (burst_left[i] != 0) quiet = 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_clients();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req[i]                   = (burst_left[i] != 0) && !(drop_early[i] && in_burst[i]);
            bus.req_len[i*LEN_W +: LEN_W] = LEN_W'(cur_len[i]);
            bus.tx_data[i*8 +: 8]        = cur_byte[i];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REQ; i++) begin
            burst_left[i] = 0; cur_len[i] = 0; cur_idx[i] = 0;
            cur_byte[i] = '0; drop_early[i] = 0; in_burst[i] = 0;
        end
        exp_q.delete(); dir_q.delete(); grant_log.delete();
        last_w = NUM_REQ - 1; act_w = -1; act_len = 0; rx_left = 0; n_start = 0;
        rand_mode = 0; arb_next = 0; core_stuck = 0; prev_grant = '0;
        core_phase = 0; core_cnt = 0; core_latch = '0;
        spi_busy = 1'b0; spi_data_out = '0;
        drive_clients();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {bus.grant, bus.tx_pop, bus.rx_valid, bus.done, spi_start, err}, 0);
        chk({tag, "_dat"}, {bus.rx_data, spi_data_in}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
    endtask

    task automatic end_burst(input int w);
        cur_idx[w] = 0;
        burst_left[w]--;
        if (rand_mode) cur_len[w] = $urandom_range(0, 3);
    endtask

    // One clock: check the registered outputs, then respond as clients and core.
    task automatic step();
        logic [10:0] e;
        int          w;
        bit          done_seen;
        done_seen = 0;
        @(posedge clk);
        #1;
        if (arb_next) begin
            chk("arb_lat", {31'd0, bus.grant != '0}, 1);
            arb_next = 0;
        end
        if (bus.grant != '0 && bus.grant != prev_grant) begin
            chk("grant_overlap", {31'd0, act_w < 0}, 1);
            w = rr_expect(bus.req, last_w);
            chk("grant", bus.grant, oh(w));
            if (w >= 0) begin
                act_w = w; act_len = cur_len[w]; rx_left = cur_len[w] + 1;
                in_burst[w] = 1; grant_log.push_back(w);
            end
        end
        if (spi_start || bus.tx_pop != '0) begin
            n_start++;
            chk("spi_start", {31'd0, spi_start}, 1);
            chk("tx_pop", bus.tx_pop, oh(act_w));
            if (act_w >= 0) begin
                chk("spi_din", spi_data_in, cur_byte[act_w]);
                exp_q.push_back({3'(act_w), cur_byte[act_w]});
                cur_byte[act_w] = (dir_q.size() != 0) ? dir_q.pop_front() : 8'($urandom);
                cur_idx[act_w]++;
                if (cur_idx[act_w] == act_len + 1) end_burst(act_w);
            end
        end
        if (err) begin
            done_seen = 1;
            chk("wd_done", bus.done, oh(act_w));
            chk("wd_rx", bus.rx_valid, 0);
            chk("grant_clr", bus.grant, 0);
            if (act_w >= 0) begin
                for (int j = exp_q.size() - 1; j >= 0; j--)
                    if (exp_q[j][10:8] == 3'(act_w)) exp_q.delete(j);
                if (cur_idx[act_w] != 0) end_burst(act_w);
                last_w = act_w; in_burst[act_w] = 0; act_w = -1;
            end
        end else if (bus.rx_valid != '0 || bus.done != '0) begin
            if (bus.rx_valid != '0) begin
                chk("rx_valid", bus.rx_valid, oh(act_w));
                if (exp_q.size() == 0) chk("rx_extra", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rx_data", {3'(act_w), bus.rx_data}, e);
                end
                rx_left--;
            end
            chk("done", bus.done, (act_w >= 0 && rx_left == 0) ? oh(act_w) : '0);
            if (act_w >= 0 && rx_left == 0) begin
                done_seen = 1;
                chk("grant_clr", bus.grant, 0);
                last_w = act_w; in_burst[act_w] = 0; act_w = -1;
            end
        end
        // loopback core: start -> short delay -> busy for a few cycles -> echo the byte
        if (core_stuck) spi_busy = 1'b1;
        else begin
            if (spi_start) begin
                core_latch = spi_data_in; core_cnt = $urandom_range(0, 2); core_phase = 1;
            end
            if (core_phase == 1) begin
                if (core_cnt == 0) begin
                    spi_busy = 1'b1; spi_data_out = 8'($urandom);
                    core_cnt = $urandom_range(1, 5); core_phase = 2;
                end else core_cnt--;
            end else if (core_phase == 2) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    spi_busy = 1'b0; spi_data_out = core_latch; core_phase = 0;
                end
            end
        end
        drive_clients();
        if (done_seen && bus.req != '0) arb_next = 1;
        prev_grant = bus.grant;
    endtask

    task automatic run(input int budget, input string tag);
        int t;
        t = 0;
        while (!quiet() && t < budget) begin
            step();
            t++;
        end
        chk({tag, "_finished"}, {31'd0, quiet()}, 1);
        chk({tag, "_rx_drained"}, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        int t;
        do_reset();

        // single byte, loopback 0xA5
        burst_left[0] = 1; cur_len[0] = 0; cur_byte[0] = 8'hA5; drive_clients();
        run(200, "t1");
        chk("t1_starts", n_start, 1);
        chk("t1_bursts", grant_log.size(), 1);

        // three-byte burst 0x11, 0x22, 0x33
        do_reset();
        burst_left[2] = 1; cur_len[2] = 2; cur_byte[2] = 8'h11;
        dir_q.push_back(8'h22); dir_q.push_back(8'h33); drive_clients();
        run(300, "t2");
        chk("t2_starts", n_start, 3);

        // all four held, two single-byte bursts each: strict rotation
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            burst_left[i] = 2; cur_len[i] = 0; cur_byte[i] = 8'($urandom);
        end
        drive_clients();
        run(800, "t3");
        chk("t3_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("t3_order", grant_log[i], exp_order[i]);

        // req dropped right after grant still completes both bytes
        do_reset();
        burst_left[1] = 1; cur_len[1] = 1; cur_byte[1] = 8'hC3; drop_early[1] = 1; drive_clients();
        run(300, "t4");
        chk("t4_starts", n_start, 2);

        // all-ones length gives 16 bytes
        do_reset();
        burst_left[0] = 1; cur_len[0] = 15; cur_byte[0] = 8'h01; drive_clients();
        run(1500, "t5");
        chk("t5_starts", n_start, 16);

        // reset in WAIT_DONE, then a lone req[3] wins
        do_reset();
        burst_left[0] = 1; cur_len[0] = 3; cur_byte[0] = 8'h3C; drive_clients();
        t = 0;
        while (dbg_state != 2'd3 && t < 50) begin step(); t++; end
        chk("rm_reach", dbg_state, 3);
        rst = 1'b1;
        #1;
        chk_zero("rm_rst");
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        burst_left[3] = 1; cur_len[3] = 0; cur_byte[3] = 8'h5A; drive_clients();
        run(200, "rm");
        chk("rm_first", (grant_log.size() != 0) ? grant_log[0] : -1, 3);

`ifdef SPI_ARB_WDOG_EN
        // core hangs busy: abort after WDOG_CYC cycles in WAIT_DONE, then next requester
        do_reset();
        burst_left[0] = 1; cur_len[0] = 1; cur_byte[0] = 8'h77;
        burst_left[1] = 1; cur_len[1] = 0; cur_byte[1] = 8'h88;
        core_stuck = 1; drive_clients();
        t = 0;
        while (dbg_state != 2'd3 && t < 50) begin step(); t++; end
        chk("wd_reach", dbg_state, 3);
        t = 0;
        while (!err && t < 200) begin step(); t++; end
        chk("wd_lat", t, WDOG_CYC);
        core_stuck = 0; core_phase = 0; spi_busy = 1'b0;
        run(300, "wd");
        chk("wd_count", grant_log.size(), 2);
        chk("wd_next", (grant_log.size() == 2) ? grant_log[1] : -1, 1);
`endif

        // randomized rounds, model carries over between rounds
        do_reset();
        rand_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                burst_left[i] = $urandom_range(0, 3);
                cur_len[i]    = $urandom_range(0, 3);
                cur_byte[i]   = 8'($urandom);
                drop_early[i] = 1'($urandom_range(0, 1));
            end
            drive_clients();
            run(3000, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "bench timeout");
    end
endmodule
